// File: rtl/disp_pkg.sv
// Shared constants for the multiplexed 7-segment display scanner.
// Segment vectors are active-low, bit 0 = segment a through bit 6 = segment g.
package disp_pkg;

  localparam int MAX_DIGITS = 8;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  localparam logic [6:0] GLYPH_0 = 7'h40;
  localparam logic [6:0] GLYPH_1 = 7'h79;
  localparam logic [6:0] GLYPH_2 = 7'h24;
  localparam logic [6:0] GLYPH_3 = 7'h30;
  localparam logic [6:0] GLYPH_4 = 7'h19;
  localparam logic [6:0] GLYPH_5 = 7'h12;
  localparam logic [6:0] GLYPH_6 = 7'h02;
  localparam logic [6:0] GLYPH_7 = 7'h78;
  localparam logic [6:0] GLYPH_8 = 7'h00;
  localparam logic [6:0] GLYPH_9 = 7'h10;
  localparam logic [6:0] GLYPH_A = 7'h08;
  localparam logic [6:0] GLYPH_B = 7'h03;
  localparam logic [6:0] GLYPH_C = 7'h46;
  localparam logic [6:0] GLYPH_D = 7'h21;
  localparam logic [6:0] GLYPH_E = 7'h06;
  localparam logic [6:0] GLYPH_F = 7'h0E;

  // Product is formed at 32 bits so that (brightness+1)*div never truncates before the shift.
  function automatic int unsigned calc_on_limit(input logic [3:0] bri, input int unsigned div);
    return ((32'(bri) + 32'd1) * div) >> 4;
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Nibble to active-low hex glyph decoder (0-9, A, b, C, d, E, F).
module seg7_decoder
  import disp_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_OFF;
    case (nibble_i)
      4'h0: seg_o = GLYPH_0;
      4'h1: seg_o = GLYPH_1;
      4'h2: seg_o = GLYPH_2;
      4'h3: seg_o = GLYPH_3;
      4'h4: seg_o = GLYPH_4;
      4'h5: seg_o = GLYPH_5;
      4'h6: seg_o = GLYPH_6;
      4'h7: seg_o = GLYPH_7;
      4'h8: seg_o = GLYPH_8;
      4'h9: seg_o = GLYPH_9;
      4'hA: seg_o = GLYPH_A;
      4'hB: seg_o = GLYPH_B;
      4'hC: seg_o = GLYPH_C;
      4'hD: seg_o = GLYPH_D;
      4'hE: seg_o = GLYPH_E;
      4'hF: seg_o = GLYPH_F;
      default: seg_o = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed 7-segment scanner with PWM brightness and leading-zero suppression.
// Optional per-digit blinking is compiled in when DISP_BLINK_EN is defined.
module display_scan_ctrl
  import disp_pkg::*;
#(
  parameter int N_DIGITS     = 6,
  parameter int DIV          = 1000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*N_DIGITS-1:0] digits,
  input  logic [N_DIGITS-1:0]   dp,
  input  logic [N_DIGITS-1:0]   blank,
  input  logic                  lz_supp,
  input  logic [3:0]            brightness,
`ifdef DISP_BLINK_EN
  input  logic [N_DIGITS-1:0]   blink,
`endif
  output logic [N_DIGITS-1:0]   an,
  output logic [6:0]            seg,
  output logic                  dp_out,
  output logic                  frame_tick
);

  if (N_DIGITS < 2 || N_DIGITS > MAX_DIGITS || DIV < 4 || BLINK_FRAMES < 1) begin : g_param_check
    $error("display_scan_ctrl: parameter out of range");
  end

  localparam int CW = $clog2(DIV);
  localparam int SW = $clog2(N_DIGITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [SW-1:0] SEL_LAST = SW'(N_DIGITS - 1);

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [SW-1:0]         sel_q, sel_d;
  logic                  slot_end, frame_end;

  logic [4*N_DIGITS-1:0] digits_q;
  logic [N_DIGITS-1:0]   dp_q;
  logic [N_DIGITS-1:0]   blank_q;
  logic                  lz_q;
  logic [3:0]            bri_q;

  logic [N_DIGITS-1:0]   an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_out_q, dp_out_d;
  logic                  frame_tick_q;

  logic [3:0]            nibble;
  logic [6:0]            glyph;
  logic                  upper_zero;
  logic                  suppressed;
  logic                  blink_off;
  logic                  dark;
  logic                  lit;
  int unsigned           on_limit;

  always_comb begin
    slot_end  = (cnt_q == CNT_LAST);
    frame_end = slot_end && (sel_q == SEL_LAST);
    cnt_d     = slot_end ? '0 : cnt_q + 1'b1;
    sel_d     = sel_q;
    if (slot_end) sel_d = (sel_q == SEL_LAST) ? '0 : sel_q + 1'b1;
  end

  // A digit is a leading zero when it and every more significant nibble are zero.
  always_comb begin
    upper_zero = 1'b1;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (SW'(i) >= sel_q && digits_q[4*i +: 4] != 4'h0) upper_zero = 1'b0;
    end
  end

  assign nibble     = digits_q[{sel_q, 2'b00} +: 4];
  assign suppressed = lz_q && (sel_q != '0) && upper_zero;
  assign on_limit   = calc_on_limit(bri_q, DIV);

`ifdef DISP_BLINK_EN
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

  logic [N_DIGITS-1:0] blink_q;
  logic [FW-1:0]       frame_cnt_q;
  logic                phase_q;

  // Phase flips on the same edge that starts a new frame, so a frame is never split.
  always_ff @(posedge clk) begin
    if (rst) begin
      blink_q     <= '0;
      frame_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else begin
      if (cnt_q == '0) blink_q <= blink;
      if (frame_end) begin
        if (frame_cnt_q == FRAME_LAST) begin
          frame_cnt_q <= '0;
          phase_q     <= ~phase_q;
        end else begin
          frame_cnt_q <= frame_cnt_q + 1'b1;
        end
      end
    end
  end

  assign blink_off = phase_q && blink_q[sel_q];
`else
  assign blink_off = 1'b0;
`endif

  assign dark = blank_q[sel_q] || suppressed || blink_off;

  // cnt==0 is kept dark so the anode switch never overlaps stale segment data.
  assign lit = (cnt_q != '0) && (32'(cnt_q) < on_limit) && !dark;

  seg7_decoder u_seg7_decoder (
    .nibble_i (nibble),
    .seg_o    (glyph)
  );

  always_comb begin
    an_d     = '1;
    seg_d    = SEG_OFF;
    dp_out_d = 1'b1;
    if (lit) begin
      an_d     = ~(N_DIGITS'(1) << sel_q);
      seg_d    = glyph;
      dp_out_d = ~dp_q[sel_q];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      sel_q        <= '0;
      digits_q     <= '0;
      dp_q         <= '0;
      blank_q      <= '0;
      lz_q         <= 1'b0;
      bri_q        <= '0;
      an_q         <= '1;
      seg_q        <= SEG_OFF;
      dp_out_q     <= 1'b1;
      frame_tick_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      sel_q        <= sel_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_out_q     <= dp_out_d;
      frame_tick_q <= frame_end;
      if (cnt_q == '0) begin
        digits_q <= digits;
        dp_q     <= dp;
        blank_q  <= blank;
        lz_q     <= lz_supp;
        bri_q    <= brightness;
      end
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp_out     = dp_out_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench for display_scan_ctrl: a cycle-index reference model predicts every output
// cycle into exp_q and a negedge monitor compares; blink checks apply when DISP_BLINK_EN is set.
module tb_display_scan_ctrl;

  localparam int N     = 6;
  localparam int DIV   = 16;
  localparam int BF    = 2;
  localparam int FRAME = N * DIV;
  localparam int W     = N + 9;
`ifdef DISP_BLINK_EN
  localparam bit BLINK_ON = 1'b1;
`else
  localparam bit BLINK_ON = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic [4*N-1:0] digits;
  logic [N-1:0]   dp, blank, blink_in;
  logic           lz_supp;
  logic [3:0]     brightness;
  logic [N-1:0]   an;
  logic [6:0]     seg;
  logic           dp_out;
  logic           frame_tick;

  always #5 clk = ~clk;

  display_scan_ctrl #(
    .N_DIGITS     (N),
    .DIV          (DIV),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .digits     (digits),
    .dp         (dp),
    .blank      (blank),
    .lz_supp    (lz_supp),
    .brightness (brightness),
`ifdef DISP_BLINK_EN
    .blink      (blink_in),
`endif
    .an         (an),
    .seg        (seg),
    .dp_out     (dp_out),
    .frame_tick (frame_tick)
  );

  // Standard hex glyphs, active-high, bit 0 = a.
  logic [6:0] hex_ah [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic [W-1:0] exp_q[$];
  int vectors     = 0;
  int miscompares = 0;

  // Reference model: position in the scan follows from cycles elapsed since reset.
  initial begin : model
    int             k, c, s, f, on_lim;
    logic [4*N-1:0] snap_digits;
    logic [N-1:0]   snap_dp, snap_blank, snap_blink;
    logic           snap_lz, is_dark, is_lit, e_ft;
    logic [3:0]     snap_bri, nib;
    logic [N-1:0]   e_an;
    logic [6:0]     e_seg;
    logic           e_dp;
    k = 0;
    forever begin
      @(posedge clk);
      if (rst) begin
        k           = 0;
        snap_digits = '0;
        snap_dp     = '0;
        snap_blank  = '0;
        snap_blink  = '0;
        snap_lz     = 1'b0;
        snap_bri    = '0;
        exp_q.push_back({{N{1'b1}}, 7'h7F, 1'b1, 1'b0});
      end else begin
        c = k % DIV;
        s = (k / DIV) % N;
        f = k / FRAME;
        if (c == 0) begin
          snap_digits = digits;
          snap_dp     = dp;
          snap_blank  = blank;
          snap_blink  = blink_in;
          snap_lz     = lz_supp;
          snap_bri    = brightness;
        end
        on_lim  = ((int'(snap_bri) + 1) * DIV) / 16;
        nib     = 4'(snap_digits >> (4 * s));
        is_dark = snap_blank[s]
                  || (snap_lz && s != 0 && (snap_digits >> (4 * s)) == 0)
                  || (BLINK_ON && snap_blink[s] && ((f / BF) % 2) == 1);
        is_lit  = (c >= 1) && (c < on_lim) && !is_dark;
        e_an    = is_lit ? ~(N'(1) << s) : {N{1'b1}};
        e_seg   = is_lit ? ~hex_ah[nib] : 7'h7F;
        e_dp    = is_lit ? ~snap_dp[s] : 1'b1;
        e_ft    = ((k + 1) % FRAME) == 0;
        exp_q.push_back({e_an, e_seg, e_dp, e_ft});
        k++;
      end
    end
  end

  initial begin : monitor
    logic [W-1:0] exp_v, act_v;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        act_v = {an, seg, dp_out, frame_tick};
        vectors++;
        if (act_v !== exp_v) begin
          miscompares++;
          $display("FAIL scan_out t=%0t got an=%b seg=%h dp=%b ft=%b want an=%b seg=%h dp=%b ft=%b",
                   $time, act_v[W-1 -: N], act_v[8:2], act_v[1], act_v[0],
                   exp_v[W-1 -: N], exp_v[8:2], exp_v[1], exp_v[0]);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns on the negedge of the cycle in which frame_tick is high (slot 0, cnt 0).
  task automatic wait_frame();
    int waited;
    waited = 0;
    while (frame_tick !== 1'b1 && waited < 2 * FRAME) begin
      @(negedge clk);
      waited++;
    end
    if (frame_tick !== 1'b1) begin
      vectors++;
      miscompares++;
      $display("FAIL frame_tick_timeout got ft=%b want 1 within %0d cycles", frame_tick, 2 * FRAME);
    end
  endtask

  task automatic random_inputs();
    int nz;
    logic [4*N-1:0] mask;
    nz         = $urandom_range(0, N);
    mask       = (nz == N) ? {4*N{1'b1}} : ((4*N)'(1) << (4 * nz)) - 1'b1;
    digits     = (4*N)'($urandom) & mask;
    dp         = N'($urandom);
    blank      = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
    blink_in   = N'($urandom);
    lz_supp    = 1'($urandom);
    brightness = 4'($urandom);
  endtask

  initial begin : driver
    rst        = 1'b1;
    digits     = '0;
    dp         = '0;
    blank      = '0;
    blink_in   = '0;
    lz_supp    = 1'b0;
    brightness = '0;
    tick(3);
    rst = 1'b0;

    // Full brightness scan of 0x123456.
    digits     = 24'h123456;
    brightness = 4'd15;
    tick(2 * FRAME);

    // Reduced duty: on_limit 4, anode low for cnt 1..3.
    brightness = 4'd3;
    tick(FRAME);

    // Leading-zero suppression.
    lz_supp = 1'b1;
    digits  = 24'h000400;
    tick(2 * FRAME);

    // Mid-slot change must not disturb the slot already captured.
    lz_supp    = 1'b0;
    brightness = 4'd15;
    digits     = 24'h000001;
    wait_frame();
    tick(2);
    digits = 24'h000009;
    tick(2 * FRAME);

    // Decimal points, blanking, minimum brightness.
    dp    = 6'b000101;
    blank = 6'b010000;
    tick(FRAME);
    brightness = 4'd0;
    tick(FRAME);
    brightness = 4'd15;
    blank      = '0;

    // Reset pulse during slot 3.
    wait_frame();
    tick(3 * DIV + 5);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(2 * FRAME);

    // Blink on digit 0 (dark every other BF frames when compiled in).
    dp       = '0;
    digits   = 24'h000007;
    blink_in = 6'b000001;
    tick(4 * BF * FRAME);
    blink_in = '0;

    for (int i = 0; i < 60; i++) begin
      random_inputs();
      if ($urandom_range(0, 19) == 0) begin
        rst = 1'b1;
        tick($urandom_range(1, 3));
        rst = 1'b0;
      end
      tick($urandom_range(1, 60));
    end

    tick(4);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/display_scan_ctrl.md
DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 SHALL have parameter N_DIGITS, default 6, number of multiplexed digits (2..8).
REQ-002 SHALL have parameter DIV, default 1000, clk cycles per digit slot (>=4).
REQ-003 SHALL have parameter BLINK_FRAMES, default 64, frames per blink half-period (used only under DISP_BLINK_EN).
REQ-004 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have port digits  in  4*N_DIGITS  BCD/hex nibbles; digit i at [4i+3:4i], digit 0 least significant.
REQ-007 SHALL have port dp  in  N_DIGITS  decimal point request per digit, 1 = lit.
REQ-008 SHALL have port blank  in  N_DIGITS  force digit dark, 1 = dark.
REQ-009 SHALL have port lz_supp  in  1  leading-zero suppression enable.
REQ-010 SHALL have port brightness  in  4  duty level 0..15.
REQ-011 SHALL have port blink  in  N_DIGITS  per-digit blink request (present only under DISP_BLINK_EN).
REQ-012 SHALL have port an  out  N_DIGITS  active-low anode enables.
REQ-013 SHALL have port seg  out  7  active-low segments a..g.
REQ-014 SHALL have port dp_out  out  1  active-low decimal point.
REQ-015 SHALL have port frame_tick  out  1  one-cycle pulse at end of each full scan.

Function
REQ-016 SHALL count cnt 0..DIV-1; on cnt==DIV-1, cnt wraps to 0 and sel advances, wrapping from N_DIGITS-1 to 0.
REQ-017 SHALL capture digits, dp, blank, lz_supp, brightness (and blink) into a slot register when cnt==0; changes mid-slot SHALL NOT affect the current slot.
REQ-018 SHALL compute on_limit = ((brightness+1)*DIV)>>4 from captured brightness, at full width with no truncation before the shift.
REQ-019 SHALL enable the selected anode only while 1 <= cnt < on_limit; cnt==0 is always dark (ghosting guard).
REQ-020 SHALL hold all anodes high outside the enabled window; seg and dp_out SHALL be all-ones whenever no anode is enabled.
REQ-021 SHALL suppress digit i when lz_supp=1, digit i nibble is 0, all more significant nibbles are 0, and i != 0.
REQ-022 SHALL treat a dark digit (blank, suppressed, or blink-off) as anode high for the whole slot.
REQ-023 SHALL register an, seg, dp_out: outputs in cycle t+1 reflect cnt/sel in cycle t.
REQ-024 SHALL pulse frame_tick for exactly one cycle in the cycle after sel wraps N_DIGITS-1 -> 0.
REQ-025 SHALL decode nibbles 0..F to standard hex glyphs.

Reset
REQ-026 SHALL on rst=1 set cnt=0, sel=0, an=all ones, seg=7'h7F, dp_out=1, frame_tick=0, slot register=0, blink phase=0.
REQ-027 SHALL, on rst asserted mid-slot, take effect on the next edge; the first slot after release SHALL be digit 0 with a fresh capture.

Configuration
REQ-028 SHALL implement blink when macro DISP_BLINK_EN is defined: frame counter toggles blink phase every BLINK_FRAMES frame_ticks; digits with captured blink=1 are dark while phase=1.
REQ-029 SHALL, without DISP_BLINK_EN, omit the blink port, frame counter and phase; behaviour otherwise identical.

Structure
REQ-030 SHALL place segment glyph constants, SEG_OFF (7'h7F) and MAX_DIGITS (8) in shared package disp_pkg.
REQ-031 SHALL instantiate the existing seg7_decoder sub-module for nibble-to-segment decoding; no other sub-modules.

Verification
REQ-032 SHALL verify N=6, DIV=4, brightness=15, digits=0x123456: an cycles 111110,111101,...,011111 with seg glyphs 6,5,4,3,2,1; frame_tick every 24 cycles.
REQ-033 SHALL verify DIV=16, brightness=3: on_limit=4, anode low for exactly 3 cycles (cnt 1..3) per slot.
REQ-034 SHALL verify lz_supp=1, digits=0x000400: digits 5,4,3 dark; digit 2 shows 4; digits 1,0 show 0.
REQ-035 SHALL verify changing digits from 0x000001 to 0x000009 at cnt==2 of slot 0: slot 0 shows 1, next visit shows 9.
REQ-036 SHALL verify rst pulse during slot 3: next cycle an=all ones, seg=7F; after release the first lit digit is 0 at cnt==1.
REQ-037 SHALL verify, with DISP_BLINK_EN and BLINK_FRAMES=2, blink=000001: digit 0 lit 2 frames, dark 2 frames, repeating.
